// File: rtl/noc_rr_packet_arbiter_pkg.sv
// Shared definitions for the NoC output-port arbiter: state encoding, router
// port order, defaults and small index helpers.
package noc_arb_pkg;

    localparam int NUM_PORTS_DEF        = 5;
    localparam int FLITS_PER_PACKET_DEF = 8;
    localparam int MAX_PORTS            = 32;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int SOUTH = 2;
    localparam int EAST  = 3;
    localparam int WEST  = 4;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } arb_state_e;

    // OR-reduction of set bit positions; exact for a one-hot or zero input.
    function automatic logic [4:0] onehot2idx(input logic [MAX_PORTS-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++)
            if (oh[i]) idx = idx | 5'(i);
        return idx;
    endfunction

    function automatic logic [4:0] ptr_inc(input logic [4:0] ptr, input int unsigned n);
        return (32'(ptr) >= n - 1) ? 5'd0 : ptr + 5'd1;
    endfunction

endpackage

// File: rtl/noc_rr_packet_arbiter_if.sv
// Request/grant bundle between the input ports and one router output port.
interface noc_rr_packet_arbiter_if
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int IDX_W     = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0] request;
    logic [NUM_PORTS-1:0] req_tail;
    logic                 out_ready;
    logic [NUM_PORTS-1:0] grant_vec;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic                 write_request;
    logic                 packet_done;

    modport master (
        output request, req_tail, out_ready,
        input  grant_vec, grant_idx, grant_valid, write_request, packet_done
    );

    modport slave (
        input  request, req_tail, out_ready,
        output grant_vec, grant_idx, grant_valid, write_request, packet_done
    );
endinterface

// File: rtl/noc_rr_packet_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping, found by a masked search over a doubled request vector.
module rr_priority_picker #(
    parameter int NUM_PORTS = 5,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_request,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic [NUM_PORTS-1:0] o_win_vec,
    output logic [IDX_W-1:0]     o_win_idx
);
    logic [IDX_W-1:0]       w_ptr;
    logic [2*NUM_PORTS-1:0] w_dbl;
    logic [2*NUM_PORTS-1:0] w_mask;
    logic [2*NUM_PORTS-1:0] w_masked;

    // Unused pointer codes of a non-power-of-2 port count behave as port 0.
    assign w_ptr = (int'(i_rr_ptr) >= NUM_PORTS) ? '0 : i_rr_ptr;

    always_comb begin
        int   pos;
        logic hit;
        pos       = 0;
        hit       = 1'b0;
        o_win_vec = '0;
        o_win_idx = '0;
        w_dbl     = {i_request, i_request};
        w_mask    = '0;
        for (int i = 0; i < 2*NUM_PORTS; i++)
            w_mask[i] = (i >= int'(w_ptr));
        w_masked = w_dbl & w_mask;
        for (int i = 2*NUM_PORTS-1; i >= 0; i--) begin
            if (w_masked[i]) begin
                hit = 1'b1;
                pos = i;
            end
        end
        if (hit) begin
            if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
            o_win_vec[pos] = 1'b1;
            o_win_idx      = IDX_W'(pos);
        end
    end
endmodule

// File: rtl/noc_rr_packet_arbiter.sv
// Round-robin wormhole arbiter for one router output port: locks a winner for a
// whole packet and ends it on a flit count or a tail marker.
module noc_rr_packet_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS        = NUM_PORTS_DEF,
    parameter int FLITS_PER_PACKET = FLITS_PER_PACKET_DEF,
    parameter int TAIL_MODE        = 0,
    parameter int IDX_W            = $clog2(NUM_PORTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    noc_rr_packet_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(FLITS_PER_PACKET + 1);

    arb_state_e           r_state,    w_state_nxt;
    logic [IDX_W-1:0]     r_rr_ptr,   w_ptr_nxt;
    logic [NUM_PORTS-1:0] r_owner,    w_owner_nxt;
    logic [CNT_W-1:0]     r_flit_cnt, w_cnt_nxt;

    logic [NUM_PORTS-1:0] w_pick_vec;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [IDX_W-1:0]     w_owner_idx;
    logic [NUM_PORTS-1:0] w_grant_vec;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_grant_valid;
    logic                 w_write;
    logic                 w_last;
    logic                 w_done;
    logic [IDX_W-1:0]     w_ptr_inc;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .i_request (bus.request),
        .i_rr_ptr  (r_rr_ptr),
        .o_win_vec (w_pick_vec),
        .o_win_idx (w_pick_idx)
    );

    assign w_owner_idx = IDX_W'(onehot2idx(MAX_PORTS'(r_owner)));

    // Outputs are forced low while reset is held, even if requests are present.
    assign w_grant_vec   = reset ? '0 : (r_state == S_LOCKED) ? r_owner     : w_pick_vec;
    assign w_grant_idx   = reset ? '0 : (r_state == S_LOCKED) ? w_owner_idx : w_pick_idx;
    assign w_grant_valid = |w_grant_vec;
    assign w_write       = w_grant_valid & |(bus.request & w_grant_vec) & bus.out_ready;
    assign w_last        = (TAIL_MODE != 0) ? |(bus.req_tail & w_grant_vec)
                                            : (r_flit_cnt == CNT_W'(FLITS_PER_PACKET - 1));
    assign w_done        = w_write & w_last;
    assign w_ptr_inc     = IDX_W'(ptr_inc(5'(w_grant_idx), NUM_PORTS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_flit_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_flit_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_flit_cnt;
        if (w_done) begin
            // Covers a single-flit packet in IDLE too: no lock is ever taken.
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = w_ptr_inc;
            w_owner_nxt = '0;
            w_cnt_nxt   = '0;
        end else begin
            if (w_write) w_cnt_nxt = r_flit_cnt + CNT_W'(1);
            if (r_state == S_IDLE && w_grant_valid) begin
                w_state_nxt = S_LOCKED;
                w_owner_nxt = w_pick_vec;
            end
        end
    end

    assign bus.grant_vec     = w_grant_vec;
    assign bus.grant_idx     = w_grant_idx;
    assign bus.grant_valid   = w_grant_valid;
    assign bus.write_request = w_write;
    assign bus.packet_done   = w_done;
endmodule

// File: tb/tb_noc_rr_packet_arbiter.sv
// Two arbiter instances (5-port fixed-length, 8-port tail mode) checked every
// cycle against a packet-level reference model, plus directed scenarios.
module tb_noc_rr_packet_arbiter;
    import noc_arb_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    noc_rr_packet_arbiter_if #(.NUM_PORTS(5)) if0 ();
    noc_rr_packet_arbiter_if #(.NUM_PORTS(8)) if1 ();

    noc_rr_packet_arbiter #(.NUM_PORTS(5), .FLITS_PER_PACKET(8), .TAIL_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    noc_rr_packet_arbiter #(.NUM_PORTS(8), .FLITS_PER_PACKET(4), .TAIL_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1));

    typedef struct { int owner; int cnt; int ptr; } mdl_t;
    mdl_t m0, m1, nm0, nm1;

    int n_chk = 0;
    int n_err = 0;

    logic [2:0] s_gidx0, s_gidx1;
    logic       s_wr0, s_done0, s_done1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet-level model: owner<0 means free; cnt counts transfers already made.
    function automatic void mdl_eval(input mdl_t m, input int n, input int f, input int tm,
                                     input logic [7:0] req, input logic [7:0] tl, input logic rdy,
                                     output int gidx, output logic wr, output logic done,
                                     output mdl_t nm);
        bit last;
        nm   = m;
        gidx = m.owner;
        wr   = 1'b0;
        done = 1'b0;
        if (gidx < 0)
            for (int k = 0; k < n; k++)
                if (gidx < 0 && req[(m.ptr + k) % n]) gidx = (m.ptr + k) % n;
        if (gidx >= 0) begin
            wr   = req[gidx] && rdy;
            last = (tm != 0) ? tl[gidx] : (m.cnt + 1 == f);
            done = wr && last;
            if (done) begin
                nm.owner = -1; nm.cnt = 0; nm.ptr = (gidx + 1) % n;
            end else begin
                nm.owner = gidx; nm.cnt = m.cnt + (wr ? 1 : 0);
            end
        end
    endfunction

    task automatic step(input logic [4:0] r0, input logic [4:0] t0, input logic y0,
                        input logic [7:0] r1, input logic [7:0] t1, input logic y1);
        int   g0, g1;
        logic w0, d0, w1, d1;
        if0.request = r0; if0.req_tail = t0; if0.out_ready = y0;
        if1.request = r1; if1.req_tail = t1; if1.out_ready = y1;
        #2;
        mdl_eval(m0, 5, 8, 0, {3'b0, r0}, {3'b0, t0}, y0, g0, w0, d0, nm0);
        mdl_eval(m1, 8, 4, 1, r1, t1, y1, g1, w1, d1, nm1);
        chk("d0_gvec", 32'(if0.grant_vec),   g0 >= 0 ? 32'(1) << g0 : 32'd0);
        chk("d0_gidx", 32'(if0.grant_idx),   g0 >= 0 ? 32'(g0) : 32'd0);
        chk("d0_gval", 32'(if0.grant_valid), 32'(g0 >= 0));
        chk("d0_wr",   32'(if0.write_request), 32'(w0));
        chk("d0_done", 32'(if0.packet_done),   32'(d0));
        chk("d1_gvec", 32'(if1.grant_vec),   g1 >= 0 ? 32'(1) << g1 : 32'd0);
        chk("d1_gidx", 32'(if1.grant_idx),   g1 >= 0 ? 32'(g1) : 32'd0);
        chk("d1_gval", 32'(if1.grant_valid), 32'(g1 >= 0));
        chk("d1_wr",   32'(if1.write_request), 32'(w1));
        chk("d1_done", 32'(if1.packet_done),   32'(d1));
        s_gidx0 = if0.grant_idx; s_wr0 = if0.write_request; s_done0 = if0.packet_done;
        s_gidx1 = if1.grant_idx; s_done1 = if1.packet_done;
        @(posedge clk); #1;
        m0 = nm0;
        m1 = nm1;
        chk("d0_ptr", 32'(u_dut0.r_rr_ptr), 32'(m0.ptr));
        chk("d1_ptr", 32'(u_dut1.r_rr_ptr), 32'(m1.ptr));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_d0_gvec", 32'(if0.grant_vec), 0);
        chk("rst_d0_gidx", 32'(if0.grant_idx), 0);
        chk("rst_d0_gval", 32'(if0.grant_valid), 0);
        chk("rst_d0_wr",   32'(if0.write_request), 0);
        chk("rst_d0_done", 32'(if0.packet_done), 0);
        chk("rst_d1_gval", 32'(if1.grant_valid), 0);
        chk("rst_d1_wr",   32'(if1.write_request), 0);
        m0 = '{-1, 0, 0};
        m1 = '{-1, 0, 0};
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int k, done_at;
        logic [4:0] r0;
        logic [7:0] r1;
        if0.request = '0; if0.req_tail = '0; if0.out_ready = 1'b0;
        if1.request = '0; if1.req_tail = '0; if1.out_ready = 1'b0;
        #3;

        // Reset state, then zero-latency grant to port 2.
        do_reset();
        step(5'b00100, 5'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        chk("idle_gidx", 32'(s_gidx0), 2);
        chk("idle_wr",   32'(s_wr0), 1);

        // Fixed-length rotation with all ports requesting: no gap between packets.
        do_reset();
        k = 0;
        for (int c = 0; c < 48; c++) begin
            step(5'b11111, 5'b0, 1'b1, 8'h00, 8'h00, 1'b1);
            if (s_done0) begin
                chk("rot_owner", 32'(s_gidx0), 32'(k % 5));
                chk("rot_cycle", 32'((c + 1) % 8), 0);
                k++;
            end
        end
        chk("rot_pkts", 32'(k), 6);

        // Backpressure on port 3: 5 transfers, 4 stalls, 3 transfers.
        do_reset();
        done_at = -1;
        for (int c = 0; c < 12; c++) begin
            step(5'b01000, 5'b0, !(c >= 5 && c < 9), 8'h00, 8'h00, 1'b1);
            chk("bp_hold", 32'(s_gidx0), 3);
            if (s_done0) done_at = c;
        end
        chk("bp_done_cyc", 32'(done_at), 11);

        // Tail mode: 3-flit packet from port 6, then single-flit from port 7.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step(5'b0, 5'b0, 1'b1, 8'h40, (c == 2) ? 8'h40 : 8'h00, 1'b1);
            chk("tail_done", 32'(s_done1), 32'(c == 2));
        end
        chk("tail_ptr", 32'(u_dut1.r_rr_ptr), 7);
        step(5'b0, 5'b0, 1'b1, 8'h80, 8'h80, 1'b1);
        chk("single_done", 32'(s_done1), 1);
        chk("single_ptr",  32'(u_dut1.r_rr_ptr), 0);
        chk("single_idle", 32'(u_dut1.r_state), 32'(S_IDLE));

        // Reset in the middle of a port-1 packet.
        do_reset();
        for (int c = 0; c < 3; c++) step(5'b00010, 5'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        do_reset();
        step(5'b00011, 5'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        chk("post_rst_gidx", 32'(s_gidx0), 0);

        // Owner port 2 drops its request while port 4 asks.
        do_reset();
        for (int c = 0; c < 2; c++) step(5'b00100, 5'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(5'b10000, 5'b0, 1'b1, 8'h00, 8'h00, 1'b1);
            chk("drop_gidx", 32'(s_gidx0), 2);
            chk("drop_wr",   32'(s_wr0), 0);
        end
        step(5'b00100, 5'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        chk("resume_gidx", 32'(s_gidx0), 2);
        chk("resume_wr",   32'(s_wr0), 1);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(399) == 0) do_reset();
            r0 = 5'($urandom) | 5'($urandom);
            r1 = 8'($urandom) | 8'($urandom);
            step(r0, 5'($urandom), $urandom_range(3) != 0,
                 r1, 8'($urandom) & 8'($urandom), $urandom_range(3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/noc_rr_packet_arbiter.md
# noc_rr_packet_arbiter

Parametrised round-robin output-port arbiter for the NoC router; it replaces the fixed 5-port, fixed 8-flit arbiter. It grants one input port for a whole packet (wormhole lock), advances only on downstream-ready flit transfers, and ends packets by either a fixed flit count or a per-port tail marker. It sits at each router output port and drives the crossbar select and the output write strobe.

## Interface
- `NUM_PORTS`, default 5: number of requesting input ports, ≥2.
- `FLITS_PER_PACKET`, default 8: flits per packet in fixed-length mode, ≥1.
- `TAIL_MODE`, default 0: 0 ends a packet on the count; 1 ends it on `req_tail`.
- `IDX_W`, default `$clog2(NUM_PORTS)`: grant index width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `request`  in  NUM_PORTS  per-port flit-valid/request.
- `req_tail`  in  NUM_PORTS  per-port "current flit is tail". Ignored when TAIL_MODE=0.
- `out_ready`  in  1  downstream can accept a flit this cycle.
- `grant_vec`  out  NUM_PORTS  one-hot grant, or all-zero.
- `grant_idx`  out  IDX_W  binary index of the granted port. This is the crossbar select.
- `grant_valid`  out  1  `grant_vec` is non-zero.
- `write_request`  out  1  flit transfers this cycle: grant_valid & request[owner] & out_ready.
- `packet_done`  out  1  one-cycle pulse on the cycle the last flit transfers.

## Operation
- **States:** IDLE and LOCKED. Registers: `state`, `rr_ptr` (IDX_W, 0..NUM_PORTS-1), `owner_reg` (one-hot), `flit_cnt`. `flit_cnt` is `$clog2(FLITS_PER_PACKET+1)` bits.
- **IDLE arbitration:**
  - Combinational priority search over `request`, starting at `rr_ptr` and wrapping modulo NUM_PORTS.
  - The winner drives `grant_vec` and `grant_idx` in the same cycle; no bubble.
  - If no request: `grant_vec`=0, `grant_idx`=0, `grant_valid`=0.
- **IDLE → LOCKED:** on any request. `owner_reg` loads the winner, whether or not a flit transfers that cycle.
  - Exception: the first flit is also the last flit (single-flit packet, or tail on first transfer). The block then stays IDLE.
- **LOCKED:** `grant_vec` = `owner_reg`. New requests from other ports are ignored.
  - Owner request low, or `out_ready` low: the block stalls. Grant is held, `write_request`=0, `flit_cnt` is unchanged.
- **Transfer:** `write_request`=1. `flit_cnt` increments on each transfer.
- **Last flit:**
  - TAIL_MODE=0: the transfer with `flit_cnt`==FLITS_PER_PACKET-1.
  - TAIL_MODE=1: the transfer with `req_tail[owner]`=1.
- **On the last-flit transfer:**
  - `packet_done`=1.
  - `flit_cnt` ← 0.
  - `rr_ptr` ← owner_idx+1, wrapping NUM_PORTS-1 → 0.
  - `state` ← IDLE.
- **Pointer rule:** `rr_ptr` changes only on packet completion, never on a stall or on the first grant.
- **Out-of-range pointer:** `rr_ptr` ≥ NUM_PORTS, which is possible for non-power-of-2 NUM_PORTS, is treated as 0.
- **Tail in fixed mode:** TAIL_MODE=0 with `req_tail` asserted has no effect.

## Timing
- **Reset values** (asynchronous): `state`=IDLE, `rr_ptr`=0, `owner_reg`=0, `flit_cnt`=0. All outputs follow combinationally: `grant_vec`=0, `grant_idx`=0, `grant_valid`=0, `write_request`=0, `packet_done`=0.
- **Reset mid-packet:** lock, count and pointer are discarded immediately. The first cycle after deassertion is IDLE with `rr_ptr`=0.
- **Grant latency:** 0 cycles from `request` rising in IDLE to `grant_vec` or `write_request`.
- **Back-to-back packets:** the cycle after `packet_done` is IDLE with the new pointer, so the next packet's first flit can transfer then. Zero idle cycles between packets.
- **Fixed-mode packet time:** exactly FLITS_PER_PACKET `write_request` cycles, any number of stall cycles interleaved.
- **Same-cycle tail in IDLE:** a tail transferring together with the first grant pulses `packet_done` and updates `rr_ptr` in that cycle.
- **Combinational paths:** all outputs are combinational from registers plus `request`, `req_tail`, `out_ready`. There is no `out_ready` → `request` path.

## Structure
- **Shared package `noc_arb_pkg`:**
  - State encoding localparams (IDLE, LOCKED).
  - `onehot2idx` function.
  - `ptr_inc` wrap function.
  - NUM_PORTS default, FLITS_PER_PACKET default, and the port-order constants LOCAL/NORTH/SOUTH/EAST/WEST = 0..4.
- **Sub-module `rr_priority_picker`:** purely combinational.
  - Inputs: `request`, `rr_ptr`.
  - Outputs: one-hot winner and index.
  - Implemented by a double-width request vector and a masked find-first.
- **Top level:** holds only the FSM, pointer, owner register and counter.

## Test plan
- **Reset and idle:** `reset` pulse with `request`=5'b00000 → all outputs 0. Then `request`=5'b00100 with `out_ready`=1 → the same cycle gives `grant_vec`=5'b00100, `grant_idx`=2, `write_request`=1.
- **Fixed-length rotation:** TAIL_MODE=0, FLITS=8, `request`=5'b11111 held → grants 0,1,2,3,4,0 in order. Each owner gets 8 consecutive `write_request` cycles, `packet_done` fires every 8 cycles, and there are no gap cycles.
- **Backpressure:** port 3 owns the lock and `out_ready` drops for 4 cycles at flit 5 → grant holds on 3, `write_request`=0, and the packet completes after 8 transfers (12 cycles total).
- **Tail mode:** TAIL_MODE=1, NUM_PORTS=8, port 6 sends 3 flits with tail on the 3rd → `packet_done` on transfer 3 and `rr_ptr`=7. Then a single-flit packet from port 7 → stays IDLE and `rr_ptr` wraps to 0.
- **Mid-packet reset:** assert `reset` at flit 4 of port 1 → outputs go to 0 immediately. After release, `request`=5'b00011 → port 0 is granted (`rr_ptr`=0).
- **Owner drop:** owner port 2 deasserts `request` mid-packet while port 4 requests → grant stays on 2 with `write_request`=0 until port 2 resumes.
